// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: access FSM states, the word-alignment
// mask and the register-index width used by the pipeline registers.
package mem_access_unit_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam int          REG_IDX_W       = 5;

endpackage

// File: rtl/mem_access_unit_memwb_reg.sv
// MEM/WB pipeline register. Loads the retiring op or inserts a bubble, which
// clears the control/flag fields but leaves the data fields untouched.
module memwb_reg
  import mem_access_unit_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 reg_write_i,
  input  logic                 memto_reg_i,
  input  logic [31:0]          alu_res_i,
  input  logic [31:0]          rddata_i,
  input  logic [REG_IDX_W-1:0] wb_path_i,
  input  logic                 misalign_i,
  input  logic                 bus_err_i,
  output logic                 reg_write_o,
  output logic                 memto_reg_o,
  output logic [31:0]          alu_res_o,
  output logic [31:0]          rddata_o,
  output logic [REG_IDX_W-1:0] wb_path_o,
  output logic                 misalign_o,
  output logic                 bus_err_o
);

  logic                 reg_write_q, reg_write_d;
  logic                 memto_reg_q, memto_reg_d;
  logic [31:0]          alu_res_q, alu_res_d;
  logic [31:0]          rddata_q, rddata_d;
  logic [REG_IDX_W-1:0] wb_path_q, wb_path_d;
  logic                 misalign_q, misalign_d;
  logic                 bus_err_q, bus_err_d;

  always_comb begin
    reg_write_d = 1'b0;
    memto_reg_d = 1'b0;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    alu_res_d   = alu_res_q;
    rddata_d    = rddata_q;
    wb_path_d   = wb_path_q;
    if (load_i) begin
      reg_write_d = reg_write_i;
      memto_reg_d = memto_reg_i;
      misalign_d  = misalign_i;
      bus_err_d   = bus_err_i;
      alu_res_d   = alu_res_i;
      rddata_d    = rddata_i;
      wb_path_d   = wb_path_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      alu_res_q   <= '0;
      rddata_q    <= '0;
      wb_path_q   <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      alu_res_q   <= alu_res_d;
      rddata_q    <= rddata_d;
      wb_path_q   <= wb_path_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign reg_write_o = reg_write_q;
  assign memto_reg_o = memto_reg_q;
  assign alu_res_o   = alu_res_q;
  assign rddata_o    = rddata_q;
  assign wb_path_o   = wb_path_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: handshakes with the multi-cycle data memory, stalls the upstream
// pipeline while an access is outstanding, and feeds the MEM/WB register.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic                 RegWrite_i,
  input  logic                 MemtoReg_i,
  input  logic [31:0]          ALUres_i,
  input  logic [31:0]          wrdata_i,
  input  logic [REG_IDX_W-1:0] WriteBackPath_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [31:0]          mem_wdata_o,
  input  logic                 mem_ack_i,
  input  logic [31:0]          mem_rdata_i,
  output logic                 stall_o,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic [31:0]          ALUres_o,
  output logic [31:0]          rddata_o,
  output logic [REG_IDX_W-1:0] WriteBackPath_o,
  output logic                 misalign_o,
  output logic                 bus_err_o
);

  localparam bit              TO_EN   = (TIMEOUT_CYC != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic        memop, aligned, stall;
  logic        wb_load, wb_reg_write, wb_misalign, wb_bus_err;
  logic [31:0] wb_rddata;

  assign memop   = MemRead_i | MemWrite_i;
  assign aligned = (ALUres_i[1:0] == 2'b00);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stall        = 1'b0;
    wb_load      = 1'b0;
    wb_reg_write = RegWrite_i;
    wb_rddata    = '0;
    wb_misalign  = 1'b0;
    wb_bus_err   = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    unique case (state_q)
      IDLE: begin
        if (memop && aligned) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = '0;
        end else if (memop) begin
          wb_load      = 1'b1;
          wb_reg_write = 1'b0;
          wb_misalign  = 1'b1;
        end else begin
          wb_load = 1'b1;
        end
      end
      ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = MemWrite_i;
        mem_addr_o  = ALUres_i & WORD_ALIGN_MASK;
        mem_wdata_o = wrdata_i;
        // Ack wins over a timeout that expires in the same cycle.
        if (mem_ack_i) begin
          wb_load   = 1'b1;
          wb_rddata = MemWrite_i ? 32'h0 : mem_rdata_i;
          state_d   = IDLE;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          wb_load      = 1'b1;
          wb_reg_write = 1'b0;
          wb_bus_err   = 1'b1;
          state_d      = IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Upstream must never be frozen while reset is being applied.
  assign stall_o = stall & ~rst_i;

  memwb_reg u_memwb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (wb_load),
    .reg_write_i (wb_reg_write),
    .memto_reg_i (MemtoReg_i),
    .alu_res_i   (ALUres_i),
    .rddata_i    (wb_rddata),
    .wb_path_i   (WriteBackPath_i),
    .misalign_i  (wb_misalign),
    .bus_err_i   (wb_bus_err),
    .reg_write_o (RegWrite_o),
    .memto_reg_o (MemtoReg_o),
    .alu_res_o   (ALUres_o),
    .rddata_o    (rddata_o),
    .wb_path_o   (WriteBackPath_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (TIMEOUT_CYC = 4): ALU pass-through,
// load/store handshakes, misalignment, timeout abort and reset mid-access.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [31:0] ALUres_i, wrdata_i;
  logic [4:0]  WriteBackPath_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, RegWrite_o, MemtoReg_o;
  logic [31:0] ALUres_o, rddata_o;
  logic [4:0]  WriteBackPath_o;
  logic        misalign_o, bus_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt;

  mem_access_unit #(.TIMEOUT_CYC(4), .TO_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .ALUres_i(ALUres_i), .wrdata_i(wrdata_i), .WriteBackPath_i(WriteBackPath_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .ALUres_o(ALUres_o), .rddata_o(rddata_o), .WriteBackPath_o(WriteBackPath_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] wbp);
    MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; MemtoReg_i = m2r;
    ALUres_i = addr; wrdata_i = wd; WriteBackPath_i = wbp;
    #1;
  endtask

  task automatic drive_idle();
    drive_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    drive_idle();
    tick(); tick();
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req: got %b want 0", mem_req_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_stall: got %b want 0", stall_o); end
    n_checks++; if ({RegWrite_o, MemtoReg_o, misalign_o, bus_err_o} !== 4'b0) begin n_fail++; $display("[TB] FAIL rst_ctrl: got %b want 0000", {RegWrite_o, MemtoReg_o, misalign_o, bus_err_o}); end
    n_checks++; if ({ALUres_o, rddata_o, WriteBackPath_o} !== 69'h0) begin n_fail++; $display("[TB] FAIL rst_data: got %h/%h/%h want 0", ALUres_o, rddata_o, WriteBackPath_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_alu_op();
    drive_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h1234, 32'hFFFF_0000, 5'd5);
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("[TB] FAIL alu_stall: got %b want 0", stall_o); end
    tick();
    drive_idle();
    n_checks++; if (RegWrite_o !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_regwrite: got %b want 1", RegWrite_o); end
    n_checks++; if (ALUres_o !== 32'h1234) begin n_fail++; $display("[TB] FAIL alu_res: got %h want 00001234", ALUres_o); end
    n_checks++; if (WriteBackPath_o !== 5'd5) begin n_fail++; $display("[TB] FAIL alu_wbpath: got %0d want 5", WriteBackPath_o); end
    n_checks++; if (rddata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL alu_rddata: got %h want 0", rddata_o); end
  endtask

  // Ack arrives on the 4th ACCESS cycle, the same cycle the timeout would fire.
  task automatic test_load();
    stall_cnt = 0;
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_req_idle: got %b want 0", mem_req_o); end
    if (stall_o) stall_cnt++;
    tick();
    n_checks++; if ({mem_req_o, mem_we_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL ld_req_we: got %b want 10", {mem_req_o, mem_we_o}); end
    n_checks++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("[TB] FAIL ld_addr: got %h want 00000100", mem_addr_o); end
    n_checks++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_bubble: got %b want 0", RegWrite_o); end
    if (stall_o) stall_cnt++;
    tick();
    if (stall_o) stall_cnt++;
    tick();
    if (stall_o) stall_cnt++;
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_stall_ack: got %b want 0", stall_o); end
    n_checks++; if (stall_cnt !== 4) begin n_fail++; $display("[TB] FAIL ld_stall_cycles: got %0d want 4", stall_cnt); end
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    drive_idle();
    n_checks++; if (rddata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL ld_rddata: got %h want deadbeef", rddata_o); end
    n_checks++; if ({RegWrite_o, MemtoReg_o, bus_err_o} !== 3'b110) begin n_fail++; $display("[TB] FAIL ld_wb_ctrl: got %b want 110", {RegWrite_o, MemtoReg_o, bus_err_o}); end
    n_checks++; if (WriteBackPath_o !== 5'd7) begin n_fail++; $display("[TB] FAIL ld_wbpath: got %0d want 7", WriteBackPath_o); end
    n_checks++; if (mem_req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_req_drop: got %b want 0", mem_req_o); end
    tick();
    n_checks++; if (RegWrite_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ld_single_wb: got %b want 0", RegWrite_o); end
  endtask

  task automatic test_store();
    drive_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'hA5A5_A5A5, 5'd0);
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("[TB] FAIL st_stall_idle: got %b want 1", stall_o); end
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    #1;
    n_checks++; if ({mem_req_o, mem_we_o, stall_o} !== 3'b110) begin n_fail++; $display("[TB] FAIL st_req_we_stall: got %b want 110", {mem_req_o, mem_we_o, stall_o}); end
    n_checks++; if (mem_wdata_o !== 32'hA5A5_A5A5) begin n_fail++; $display("[TB] FAIL st_wdata: got %h want a5a5a5a5", mem_wdata_o); end
    n_checks++; if (mem_addr_o !== 32'h104) begin n_fail++; $display("[TB] FAIL st_addr: got %h want 00000104", mem_addr_o); end
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    drive_idle();
    n_checks++; if ({RegWrite_o, mem_req_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL st_regwrite_req: got %b want 00", {RegWrite_o, mem_req_o}); end
    n_checks++; if (rddata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL st_rddata: got %h want 0", rddata_o); end
  endtask

  task automatic test_misalign();
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd9);
    n_checks++; if ({mem_req_o, stall_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL mis_req_stall: got %b want 00", {mem_req_o, stall_o}); end
    tick();
    drive_idle();
    n_checks++; if ({misalign_o, RegWrite_o, bus_err_o, mem_req_o} !== 4'b1000) begin n_fail++; $display("[TB] FAIL mis_flags: got %b want 1000", {misalign_o, RegWrite_o, bus_err_o, mem_req_o}); end
    n_checks++; if (WriteBackPath_o !== 5'd9) begin n_fail++; $display("[TB] FAIL mis_wbpath: got %0d want 9", WriteBackPath_o); end
    tick();
    n_checks++; if (misalign_o !== 1'b0) begin n_fail++; $display("[TB] FAIL mis_pulse: got %b want 0", misalign_o); end
  endtask

  task automatic test_timeout();
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      n_checks++; if ({mem_req_o, stall_o} !== {1'b1, (i < 3)}) begin n_fail++; $display("[TB] FAIL to_access%0d: got %b want %b", i, {mem_req_o, stall_o}, {1'b1, (i < 3)}); end
      tick();
    end
    drive_idle();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    n_checks++; if ({bus_err_o, RegWrite_o, mem_req_o, stall_o} !== 4'b1000) begin n_fail++; $display("[TB] FAIL to_abort: got %b want 1000", {bus_err_o, RegWrite_o, mem_req_o, stall_o}); end
    tick();
    mem_ack_i = 1'b0;
    n_checks++; if ({bus_err_o, RegWrite_o, mem_req_o} !== 3'b000) begin n_fail++; $display("[TB] FAIL to_late_ack: got %b want 000", {bus_err_o, RegWrite_o, mem_req_o}); end
    n_checks++; if (rddata_o !== 32'h0) begin n_fail++; $display("[TB] FAIL to_late_rddata: got %h want 0", rddata_o); end
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd4);
    tick();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    tick();
    mem_ack_i = 1'b0;
    n_checks++; if ({RegWrite_o, bus_err_o} !== 2'b10) begin n_fail++; $display("[TB] FAIL to_next_ctrl: got %b want 10", {RegWrite_o, bus_err_o}); end
    n_checks++; if (rddata_o !== 32'hCAFE_F00D) begin n_fail++; $display("[TB] FAIL to_next_rddata: got %h want cafef00d", rddata_o); end
  endtask

  // Reset lands while ACCESS is outstanding and the EX/MEM op is still a load.
  task automatic test_reset_mid();
    drive_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd6);
    tick();
    tick();
    n_checks++; if (mem_req_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rm_req_before: got %b want 1", mem_req_o); end
    rst_i = 1'b1;
    tick();
    n_checks++; if ({mem_req_o, stall_o} !== 2'b00) begin n_fail++; $display("[TB] FAIL rm_req_stall: got %b want 00", {mem_req_o, stall_o}); end
    n_checks++; if ({RegWrite_o, MemtoReg_o, misalign_o, bus_err_o} !== 4'b0) begin n_fail++; $display("[TB] FAIL rm_ctrl: got %b want 0000", {RegWrite_o, MemtoReg_o, misalign_o, bus_err_o}); end
    n_checks++; if ({ALUres_o, rddata_o, WriteBackPath_o} !== 69'h0) begin n_fail++; $display("[TB] FAIL rm_data: got %h/%h/%h want 0", ALUres_o, rddata_o, WriteBackPath_o); end
    drive_idle();
    rst_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM pipeline register.
- Consumes EX/MEM outputs: control bits, ALU result/address, store data and destination register.
- Runs a request/acknowledge handshake to a multi-cycle data memory (cache) and drives the global pipeline stall while an access is outstanding.
- Contains the MEM/WB pipeline register feeding writeback.

Parameters:
TIMEOUT_CYC, 255, cycles in ACCESS without ack before abort; 0 disables timeout
TO_W, 8, width of timeout counter; must hold TIMEOUT_CYC

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  reset, synchronous, active-high
MemRead_i  in  1  load request from EX/MEM
MemWrite_i  in  1  store request from EX/MEM
RegWrite_i  in  1  writeback enable from EX/MEM
MemtoReg_i  in  1  writeback source select from EX/MEM
ALUres_i  in  32  ALU result / memory byte address
wrdata_i  in  32  store data
WriteBackPath_i  in  5  destination register
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store, 0 = load
mem_addr_o  out  32  word-aligned address
mem_wdata_o  out  32  store data
mem_ack_i  in  1  memory completion, single-cycle pulse
mem_rdata_i  in  32  load data, valid with mem_ack_i
stall_o  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM (drives EX/MEM stall_i)
RegWrite_o  out  1  MEM/WB writeback enable
MemtoReg_o  out  1  MEM/WB source select
ALUres_o  out  32  MEM/WB ALU result
rddata_o  out  32  MEM/WB load data
WriteBackPath_o  out  5  MEM/WB destination register
misalign_o  out  1  MEM/WB flag: memory op with ALUres_i[1:0] != 0
bus_err_o  out  1  MEM/WB flag: access aborted on timeout

Behaviour:
- Reset values:
  - State IDLE; timeout counter 0.
  - All outputs 0, including mem_req_o and stall_o.
- Definitions:
  - memop = MemRead_i | MemWrite_i. If both are set, a store is performed.
  - aligned = (ALUres_i[1:0] == 0).
- States:
  - IDLE: no access outstanding.
  - ACCESS: request outstanding.
- IDLE transitions:
  - memop & aligned: stall_o = 1; next state ACCESS; counter cleared.
  - memop & !aligned: no request, no stall. MEM/WB loads the op with RegWrite_o = 0 and misalign_o = 1.
  - !memop: stall_o = 0; MEM/WB loads inputs with rddata_o = 0. Latency is 1 cycle.
- ACCESS behaviour:
  - mem_req_o = 1.
  - mem_we_o = MemWrite_i.
  - mem_addr_o = {ALUres_i[31:2], 2'b00}.
  - mem_wdata_o = wrdata_i.
  - These are stable because EX/MEM is stalled.
- ACCESS with mem_ack_i:
  - stall_o = 0 in that same cycle.
  - At the edge, MEM/WB loads the op: rddata_o <= mem_rdata_i for loads, 0 for stores. Next state IDLE.
- ACCESS without ack:
  - stall_o = 1; counter increments.
  - When TIMEOUT_CYC != 0 and the counter reaches TIMEOUT_CYC - 1:
    - stall_o = 0; next state IDLE.
    - MEM/WB loads the op with RegWrite_o = 0 and bus_err_o = 1.
  - A late ack after abort is ignored.
- Minimum memory-op latency: 2 cycles (IDLE decision cycle, then ACCESS with immediate ack).
- Stalled cycles: MEM/WB loads a bubble (RegWrite_o = 0, MemtoReg_o = 0, misalign_o = 0, bus_err_o = 0). Data fields hold.
- mem_ack_i while IDLE is ignored.
- Only one request is outstanding at a time. mem_req_o deasserts in the cycle after ack, abort or reset.
- Reset mid-ACCESS: state returns to IDLE and mem_req_o drops at the next edge. The access is abandoned, and memory must tolerate the dropped request.
- misalign_o and bus_err_o are single-cycle, registered with their instruction.

Decomposition:
- Shared pipeline package: state enum (IDLE, ACCESS), word-alignment mask constant, and the 5-bit register-index width.
- One natural sub-module, memwb_reg: the MEM/WB register with load / bubble select, so the FSM and the register are verified separately.

Test Plan:
- ALU op (MemRead_i = 0, MemWrite_i = 0, RegWrite_i = 1, ALUres_i = 0x1234, WriteBackPath_i = 5) -> no stall; next edge RegWrite_o = 1, ALUres_o = 0x1234, WriteBackPath_o = 5.
- Load at 0x100, ack 3 cycles after mem_req_o with rdata 0xDEADBEEF -> stall_o high for 4 cycles; mem_addr_o = 0x100; then rddata_o = 0xDEADBEEF, MemtoReg_o = 1, single WB.
- Store at 0x104, data 0xA5A5A5A5, immediate ack -> one ACCESS cycle with mem_we_o = 1 and mem_wdata_o = 0xA5A5A5A5; stall lasts 1 cycle; RegWrite_o = 0.
- Load at 0x102 -> mem_req_o never asserts; misalign_o = 1 for one cycle; RegWrite_o = 0; no stall.
- TIMEOUT_CYC = 4, no ack -> abort after 4 ACCESS cycles; bus_err_o pulse; late ack ignored; next op proceeds normally.
- rst_i asserted on the 2nd ACCESS cycle -> next edge mem_req_o = 0, stall_o = 0, all MEM/WB outputs 0.
